// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access size codes
// and FSM state codes.
package dm_access_ctrl_pkg;

    localparam logic [1:0] DMSIZE_B = 2'b00;
    localparam logic [1:0] DMSIZE_H = 2'b01;
    localparam logic [1:0] DMSIZE_W = 2'b10;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'b00,
        DMA_REQ  = 2'b01,
        DMA_RESP = 2'b10,
        DMA_FIN  = 2'b11
    } dma_state_e;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/grant/rvalid handshake between the access controller and data memory.
interface dm_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dm_access_ctrl_lane_align.sv
// Byte-lane steering for sub-word accesses: byte enables, store-data
// replication, load-data right alignment and the alignment check.
module dm_lane_align
    import dm_access_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    // Lane enables and replicated store data selected by access size.
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (size_i)
            DMSIZE_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            DMSIZE_H: begin
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = off_i[0];
            end
            DMSIZE_W: begin
                be_o       = 4'b1111;
                misalign_o = (off_i != 2'b00);
            end
            default: misalign_o = 1'b1;
        endcase
    end

    // Upper bits are left as shifted; the load extender masks them.
    assign rdata_o = rdata_i >> {off_i, 3'b000};

endmodule

// File: rtl/dm_access_ctrl.sv
// Multicycle data-memory access controller: alignment check, req/gnt/rvalid
// handshake and right-aligned load return. All outputs are registered.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                is_store,
    input  logic [1:0]          size,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic                busy,
    output logic                done,
    output logic                misalign,
    output logic [31:0]         dmout,
    dm_access_ctrl_if.master    mem
);

    dma_state_e  state_q;
    logic [1:0]  off_q;
    logic        st_q;
    logic        busy_q, done_q, mis_q;
    logic        req_q, we_q;
    logic [31:0] maddr_q, mwdata_q, dmout_q;
    logic [3:0]  be_q;

    logic [1:0]  la_off;
    logic [3:0]  la_be;
    logic [31:0] la_wdata, la_rdata;
    logic        la_mis;

    // In IDLE the steering works on the incoming request; afterwards the
    // latched offset drives the load-data shift.
    assign la_off = (state_q == DMA_IDLE) ? addr[1:0] : off_q;

    dm_lane_align u_align (
        .size_i     (size),
        .off_i      (la_off),
        .wdata_i    (wdata),
        .rdata_i    (mem.mem_rdata),
        .be_o       (la_be),
        .wdata_o    (la_wdata),
        .rdata_o    (la_rdata),
        .misalign_o (la_mis)
    );

    // Access FSM with registered status and memory-side outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= DMA_IDLE;
            off_q    <= 2'b00;
            st_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            be_q     <= '0;
            mwdata_q <= '0;
            dmout_q  <= '0;
        end else begin
            case (state_q)
                DMA_IDLE: begin
                    if (start) begin
                        off_q  <= addr[1:0];
                        st_q   <= is_store;
                        busy_q <= 1'b1;
                        if (la_mis) begin
                            // Rejected without touching memory.
                            state_q <= DMA_FIN;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q  <= DMA_REQ;
                            req_q    <= 1'b1;
                            we_q     <= is_store;
                            maddr_q  <= {addr[31:2], 2'b00};
                            be_q     <= la_be;
                            mwdata_q <= la_wdata;
                        end
                    end
                end
                DMA_REQ: begin
                    if (mem.mem_gnt) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (st_q) begin
                            state_q <= DMA_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DMA_RESP;
                        end
                    end
                end
                DMA_RESP: begin
                    if (mem.mem_rvalid) begin
                        dmout_q <= la_rdata;
                        state_q <= DMA_FIN;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= DMA_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    mis_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign misalign      = mis_q;
    assign dmout         = dmout_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl; cycle numbers are relative to start.
module tb_dm_access_ctrl;
    import dm_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misalign;
    logic [31:0] dmout;
    int          total = 0;
    int          bad = 0;
    int          ndone, nreq;

    dm_access_ctrl_if mif();

    dm_access_ctrl dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .is_store (is_store),
        .size     (size),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .misalign (misalign),
        .dmout    (dmout),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle; returns positioned in cycle 1.
    task automatic go(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        start = 1'b1; is_store = st; size = sz; addr = a; wdata = wd;
        tick();
        start = 1'b0;
    endtask

    initial begin
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_we", mif.mem_we, 0);
        chk("rst_be", mif.mem_be, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        chk("rst_dmout", dmout, 0);
        rstn = 1'b1;
        tick();

        // Load byte at offset 3
        go(0, DMSIZE_B, 32'h1003, 0);
        chk("lb_req", mif.mem_req, 1);
        chk("lb_we", mif.mem_we, 0);
        chk("lb_addr", mif.mem_addr, 32'h1000);
        chk("lb_be", mif.mem_be, 4'b1000);
        chk("lb_busy", busy, 1);
        mif.mem_gnt = 1'b1; tick(); mif.mem_gnt = 1'b0;
        chk("lb_req_c2", mif.mem_req, 0);
        chk("lb_done_c2", done, 0);
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hA1B2C3D4; tick(); mif.mem_rvalid = 1'b0;
        chk("lb_done_c3", done, 1);
        chk("lb_mis", misalign, 0);
        chk("lb_dmout", dmout, 32'h000000A1);
        tick();
        chk("lb_done_c4", done, 0);
        chk("lb_busy_c4", busy, 0);

        // Store half with grant delayed 3 cycles
        go(1, DMSIZE_H, 32'h2002, 32'h0000BEEF);
        for (int i = 0; i < 4; i++) begin
            chk("sh_req", mif.mem_req, 1);
            chk("sh_be", mif.mem_be, 4'b1100);
            chk("sh_wdata", mif.mem_wdata, 32'hBEEFBEEF);
            chk("sh_we", mif.mem_we, 1);
            chk("sh_done", done, 0);
            if (i == 3) mif.mem_gnt = 1'b1;
            tick();
        end
        mif.mem_gnt = 1'b0;
        chk("sh_done_fin", done, 1);
        chk("sh_req_fin", mif.mem_req, 0);
        chk("sh_dmout", dmout, 32'h000000A1);
        tick();
        chk("sh_done_after", done, 0);

        // Misaligned word load
        go(0, DMSIZE_W, 32'h3001, 0);
        chk("mw_req", mif.mem_req, 0);
        chk("mw_done", done, 1);
        chk("mw_mis", misalign, 1);
        chk("mw_dmout", dmout, 32'h000000A1);
        tick();
        chk("mw_done_after", done, 0);
        chk("mw_mis_after", misalign, 0);
        chk("mw_busy_after", busy, 0);

        // Illegal size 11, aligned address
        go(0, 2'b11, 32'h7000, 0);
        chk("il_req", mif.mem_req, 0);
        chk("il_mis", misalign, 1);
        tick();

        // Odd half offset
        go(1, DMSIZE_H, 32'h7001, 32'h1234);
        chk("oh_req", mif.mem_req, 0);
        chk("oh_mis", misalign, 1);
        tick();

        // Byte store at offset 1
        go(1, DMSIZE_B, 32'h8001, 32'h12345678);
        chk("sb_be", mif.mem_be, 4'b0010);
        chk("sb_wdata", mif.mem_wdata, 32'h78787878);
        chk("sb_addr", mif.mem_addr, 32'h8000);
        mif.mem_gnt = 1'b1; tick(); mif.mem_gnt = 1'b0;
        chk("sb_done", done, 1);
        tick();

        // Spurious rvalid/gnt in IDLE
        mif.mem_rvalid = 1'b1; mif.mem_gnt = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
        tick();
        mif.mem_rvalid = 1'b0; mif.mem_gnt = 1'b0;
        chk("idle_rv_done", done, 0);
        chk("idle_rv_busy", busy, 0);
        chk("idle_rv_dmout", dmout, 32'h000000A1);

        // start during RESP is ignored
        go(0, DMSIZE_W, 32'h4000, 0);
        mif.mem_gnt = 1'b1; tick(); mif.mem_gnt = 1'b0;
        start = 1'b1; is_store = 1'b1; size = DMSIZE_B; addr = 32'h4100;
        tick();
        start = 1'b0;
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h11223344; tick(); mif.mem_rvalid = 1'b0;
        ndone = 0; nreq = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            if (mif.mem_req) nreq++;
            tick();
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_nreq", nreq, 0);
        chk("ign_dmout", dmout, 32'h11223344);

        // Half load at offset 2
        go(0, DMSIZE_H, 32'h4002, 0);
        chk("lh_be", mif.mem_be, 4'b1100);
        mif.mem_gnt = 1'b1; tick(); mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h55667788; tick(); mif.mem_rvalid = 1'b0;
        chk("lh_done", done, 1);
        chk("lh_dmout", dmout, 32'h00005566);
        tick();

        // Reset while in RESP
        go(0, DMSIZE_W, 32'h5000, 0);
        mif.mem_gnt = 1'b1; tick(); mif.mem_gnt = 1'b0;
        chk("rr_busy_pre", busy, 1);
        #1 rstn = 1'b0;
        #1;
        chk("rr_req", mif.mem_req, 0);
        chk("rr_busy", busy, 0);
        chk("rr_dmout", dmout, 0);
        rstn = 1'b1;
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
        tick();
        mif.mem_rvalid = 1'b0;
        chk("rr_done1", done, 0);
        chk("rr_dmout1", dmout, 0);
        tick();
        chk("rr_done2", done, 0);
        chk("rr_busy2", busy, 0);

        // Back-to-back word load then word store, zero-wait memory
        go(0, DMSIZE_W, 32'h6000, 0);
        mif.mem_gnt = 1'b1; tick(); mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h0BADF00D; tick(); mif.mem_rvalid = 1'b0;
        chk("bb_done3", done, 1);
        chk("bb_dmout", dmout, 32'h0BADF00D);
        tick();
        chk("bb_done4", done, 0);
        go(1, DMSIZE_W, 32'h6004, 32'hCAFEF00D);
        chk("bb_req5", mif.mem_req, 1);
        chk("bb_we5", mif.mem_we, 1);
        chk("bb_be5", mif.mem_be, 4'b1111);
        chk("bb_addr5", mif.mem_addr, 32'h6004);
        chk("bb_wdata5", mif.mem_wdata, 32'hCAFEF00D);
        mif.mem_gnt = 1'b1; tick(); mif.mem_gnt = 1'b0;
        chk("bb_done6", done, 1);
        chk("bb_mis6", misalign, 0);
        chk("bb_dmout6", dmout, 32'h0BADF00D);
        tick();
        chk("bb_done7", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Multicycle data-memory access controller for the RISC-V core. On a start pulse from the control unit's MEM state it checks alignment, drives a request/grant/rvalid handshake to data memory with byte enables and lane-replicated store data, and returns the loaded word right-aligned on `dmout`. `dmout` feeds the load-extension stage, which applies sign or zero extension. It sits between the ALU address/rs2 outputs and the load extender.

## Interface
- No parameters: address and data widths are fixed at 32.
- `clk`  in  1  core clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle access request; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load; sampled with `start`.
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal; sampled with `start`.
- `addr`  in  32  byte address; sampled with `start`.
- `wdata`  in  32  store data (rs2); sampled with `start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  valid with `done`; 1 = access was rejected without touching memory.
- `dmout`  out  32  right-aligned load data, registered.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid this cycle.
- `mem_rdata`  in  32  read word.

## Operation
- States and transitions:
  - IDLE → REQ on `start` with a legal access.
  - IDLE → FIN on `start` with a misaligned or illegal access; `misalign` is set.
  - REQ → FIN on `mem_gnt` for a store.
  - REQ → RESP on `mem_gnt` for a load.
  - RESP → FIN on `mem_rvalid`.
  - FIN → IDLE unconditionally.
- `done` is high exactly in FIN.
- Misalignment, with off = `addr[1:0]`: half with off[0]=1; word with off≠0; size 11 always. A misaligned access never asserts `mem_req`.
- Byte enables: byte `0001<<off`; half `0011<<off`; word `1111`.
- Store data: byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word `wdata`.
- Load data: `dmout <= mem_rdata >> (8*off)`, captured on `mem_rvalid` in RESP. Upper bits are left as shifted; the extender masks them.
- `dmout` holds its value through stores, misaligned accesses and idle cycles.
- `addr`, `size`, `is_store` and `wdata` are registered at start. Memory outputs come from these registers and stay stable while `mem_req` is high.
- `start` while busy is ignored.
- `mem_gnt` outside REQ and `mem_rvalid` outside RESP are ignored.
- `mem_rvalid` in the same cycle as `mem_gnt` is not accepted; the response must arrive at least one cycle after the grant.

## Timing
- Reset values: state IDLE; `busy`, `done`, `misalign`, `mem_req`, `mem_we` = 0; `mem_be` = 0; `mem_addr`, `mem_wdata`, `dmout` = 0.
- Reset mid-operation drops `mem_req` immediately, with no completion pulse; a late `mem_rvalid` after reset is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `mem_req` is high from the cycle after `start` until the cycle of `mem_gnt`, inclusive.
- Minimum store: start at cycle 0, `mem_req` + `mem_gnt` at cycle 1, `done` at cycle 2.
- Minimum load: start at cycle 0, req/gnt at cycle 1, `mem_rvalid` at cycle 2, `done` and new `dmout` at cycle 3.
- Misaligned access: start at cycle 0, `done` = `misalign` = 1 at cycle 1.
- Back-to-back: the next `start` is accepted in the cycle after FIN, when the state is IDLE again.

## Structure
- Shared constants in the common control-encoding header:
  - size codes `DMSIZE_B`, `DMSIZE_H`, `DMSIZE_W`
  - state codes `DMA_IDLE`, `DMA_REQ`, `DMA_RESP`, `DMA_FIN`
- Sub-module `dm_lane_align` (combinational): takes size, off and wdata/rdata; produces `be`, replicated wdata, shifted rdata and the misalign flag.
- The FSM and registers stay in `dm_access_ctrl`.

## Test plan
- Load byte, `addr`=0x1003, `mem_rdata`=0xA1B2C3D4, gnt at cycle 1, rvalid at cycle 2 → `mem_addr`=0x1000, `mem_be`=1000, `done` at cycle 3, `dmout`=0x000000A1.
- Store half, `addr`=0x2002, `wdata`=0x0000BEEF, gnt delayed 3 cycles → `mem_req` held 4 cycles with stable `mem_be`=1100, `mem_wdata`=0xBEEFBEEF, `mem_we`=1; `done` 1 cycle after gnt; `dmout` unchanged.
- Word load at `addr`=0x3001 → no `mem_req`; `done`=`misalign`=1 at cycle 1; `dmout` unchanged.
- `start` pulsed during RESP, plus a spurious `mem_rvalid` in IDLE → both ignored; exactly one `done` pulse and the correct `dmout`.
- `rstn` low while in RESP → `mem_req`/`busy`=0 and `dmout`=0 asynchronously; a subsequent `mem_rvalid` causes no `done`.
- Back-to-back word load then word store with zero-wait memory → `done` at cycle 3 and again at cycle 6 (second `start` at cycle 4).
